// File: rtl/ps2_key_queue_pkg.sv
// Key-queue package: scan-code constants, entry bit positions, word kinds and the entry builder.
// Wraps the shared ps2_defs.vh macros as typed localparams for the RTL.
// No logic; imported by ps2_key_queue.
`include "ps2_defs.vh"

package ps2_key_queue_pkg;

  localparam logic [7:0] PS2_BREAK_CODE = `PS2_BREAK;
  localparam logic [7:0] PS2_EXT_CODE   = `PS2_EXT;

  localparam int KQ_VALID = `KQ_VALID;
  localparam int KQ_BREAK = `KQ_BREAK;
  localparam int KQ_EXT   = `KQ_EXT;
  localparam int KQ_OVF   = `KQ_OVF;

  // What an incoming receiver word represents.
  typedef enum logic [1:0] {
    KIND_NONE  = 2'd0,
    KIND_MAKE  = 2'd1,
    KIND_BREAK = 2'd2
  } word_kind_t;

  function automatic logic [15:0] kq_entry(input logic brk, input logic ext,
                                           input logic ovf, input logic [7:0] ascii);
    logic [15:0] e;
    e           = '0;
    e[KQ_VALID] = 1'b1;
    e[KQ_BREAK] = brk;
    e[KQ_EXT]   = ext;
    e[KQ_OVF]   = ovf;
    e[7:0]      = ascii;
    return e;
  endfunction

endpackage

// File: rtl/ps2_defs.vh
// Shared PS/2 scan-code constants and key-queue entry bit positions.
// Entry layout: [15] valid, [14] break, [13] extended, [12] first entry after a drop, [7:0] ASCII.
// Include-guarded so it may be pulled in from several files of one build.
`ifndef PS2_DEFS_VH
`define PS2_DEFS_VH

`define PS2_BREAK 8'hF0
`define PS2_EXT   8'hE0

`define KQ_VALID  15
`define KQ_BREAK  14
`define KQ_EXT    13
`define KQ_OVF    12

`endif

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head read; push visible the edge after it is written.
// Ports: clk/rst_n, push+wdata, pop, rdata (0 when empty), count, push_ok/pop_ok acceptance.
// When full, a push is accepted only if a pop happens in the same cycle (pop frees the slot first).
module sync_fifo #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              pop,
  output logic [WIDTH-1:0]  rdata,
  output logic [ADDR_W:0]   count,
  output logic              push_ok,
  output logic              pop_ok
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != FULL_CNT) || pop_ok);
  assign rdata   = (count == '0) ? '0 : mem[rd_ptr];

  // Storage is not reset; the empty check above masks stale contents.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain ADDR_W-bit overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop_ok) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_queue.sv
// PS/2 key event queue: classifies receiver words as make/break/prefix and buffers key events.
// Ports: clk, rst_n, in_valid/in_data (receiver word), ren (CPU pop), q_data/q_count/overflow.
// Build option: define PS2_KEYQ_RELEASE_EN to queue BREAK events; otherwise they are dropped.
module ps2_key_queue
  import ps2_key_queue_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  input  logic              ren,
  output logic [15:0]       q_data,
  output logic [ADDR_W:0]   q_count,
  output logic              overflow
);

  logic [7:0]  hist;
  logic        pending_mark;
  logic [7:0]  prev_byte;
  logic [7:0]  ascii;
  word_kind_t  kind;
  logic        push_req;
  logic        brk;
  logic        ext;
  logic [15:0] entry;
  logic        push_ok;
  logic        pop_ok;

  assign prev_byte = in_data[15:8];
  assign ascii     = in_data[7:0];

  // Prefix bytes decode to ASCII 0, so a zero ASCII means nothing to queue.
  always_comb begin
    kind = KIND_NONE;
    if (in_valid && (ascii != 8'h00)) begin
      kind = (prev_byte == PS2_BREAK_CODE) ? KIND_BREAK : KIND_MAKE;
    end
  end

  // A break word's own predecessor is F0, so its E0 prefix sits one word further back in hist.
  always_comb begin
    ext = (kind == KIND_BREAK) ? (hist == PS2_EXT_CODE) : (prev_byte == PS2_EXT_CODE);
`ifdef PS2_KEYQ_RELEASE_EN
    push_req = (kind != KIND_NONE);
    brk      = (kind == KIND_BREAK);
`else
    push_req = (kind == KIND_MAKE);
    brk      = 1'b0;
`endif
    entry = kq_entry(brk, ext, pending_mark, ascii);
  end

  sync_fifo #(
    .WIDTH  (16),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_req),
    .wdata   (entry),
    .pop     (ren),
    .rdata   (q_data),
    .count   (q_count),
    .push_ok (push_ok),
    .pop_ok  (pop_ok)
  );

  // A rejected push can only mean full with no pop this cycle, so it can never coincide
  // with the pop that clears overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist         <= '0;
      pending_mark <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (in_valid) begin
        hist <= prev_byte;
      end
      if (push_req && !push_ok) begin
        overflow     <= 1'b1;
        pending_mark <= 1'b1;
      end else begin
        if (push_ok) begin
          pending_mark <= 1'b0;
        end
        if (pop_ok && q_data[KQ_OVF]) begin
          overflow <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_queue.sv
module tb_ps2_key_queue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        ren;
  logic [15:0] q_data;
  logic [4:0]  q_count;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  ps2_key_queue #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .ren      (ren),
    .q_data   (q_data),
    .q_count  (q_count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [15:0] mq[$];
  logic [7:0]  m_hist;
  bit          m_ovf;
  bit          m_pend;
`ifdef PS2_KEYQ_RELEASE_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  function automatic logic [15:0] m_head();
    return (mq.size() == 0) ? 16'h0000 : mq[0];
  endfunction

  function automatic logic [4:0] m_cnt();
    return 5'(mq.size());
  endfunction

  task automatic model_reset();
    mq.delete();
    m_hist = 8'h00;
    m_ovf  = 1'b0;
    m_pend = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [15:0] d, input logic r);
    logic [15:0] e;
    bit brk, ext, want;
    if (r && mq.size() > 0) begin
      e = mq.pop_front();
      if (e[12]) m_ovf = 1'b0;
    end
    if (v && d[7:0] != 8'h00) begin
      brk  = (d[15:8] == 8'hF0);
      ext  = brk ? (m_hist == 8'hE0) : (d[15:8] == 8'hE0);
      want = !brk || REL;
      if (want) begin
        if (mq.size() < 16) begin
          mq.push_back({1'b1, brk, ext, m_pend, 4'h0, d[7:0]});
          m_pend = 1'b0;
        end else begin
          m_ovf  = 1'b1;
          m_pend = 1'b1;
        end
      end
    end
    if (v) m_hist = d[15:8];
  endtask

  task automatic tick(input logic v, input logic [15:0] d, input logic r);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    ren      = r;
    @(posedge clk);
    model_step(v, d, r);
    #1;
    in_valid = 1'b0;
    ren      = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && mq.size() > 0; i++) tick(1'b0, 16'h0000, 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0; ren = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (q_data !== 16'h0000) begin errors++; $display("FAIL reset_qdata: got %h want 0000", q_data); end
    checks++; if (q_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", q_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_single();
    tick(1'b1, 16'h1C61, 1'b0);
    checks++; if (q_data !== 16'h8061) begin errors++; $display("FAIL single_head: got %h want 8061", q_data); end
    checks++; if (q_count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d want 1", q_count); end
    tick(1'b0, 16'h0000, 1'b1);
    checks++; if (q_data !== 16'h0000) begin errors++; $display("FAIL single_pop_head: got %h want 0000", q_data); end
    checks++; if (q_count !== 5'd0) begin errors++; $display("FAIL single_pop_count: got %0d want 0", q_count); end
  endtask

  task automatic test_release();
    logic [15:0] exp_h;
    logic [4:0]  exp_c;
    exp_h = REL ? 16'hC061 : 16'h0000;
    exp_c = REL ? 5'd1 : 5'd0;
    tick(1'b1, 16'h1C00, 1'b0);
    tick(1'b1, 16'hF061, 1'b0);
    checks++; if (q_count !== exp_c) begin errors++; $display("FAIL release_count: got %0d want %0d", q_count, exp_c); end
    checks++; if (q_data !== exp_h) begin errors++; $display("FAIL release_head: got %h want %h", q_data, exp_h); end
    drain();
  endtask

  task automatic test_extended();
    tick(1'b1, 16'h1C00, 1'b0);  // E0 arrives
    tick(1'b1, 16'hE02F, 1'b0);  // extended make
    tick(1'b1, 16'h2F00, 1'b0);  // E0 again
    tick(1'b1, 16'hE000, 1'b0);  // F0
    tick(1'b1, 16'hF02F, 1'b0);  // extended break
    checks++; if (q_data !== 16'hA02F) begin errors++; $display("FAIL ext_make: got %h want A02F", q_data); end
    checks++; if (q_count !== m_cnt()) begin errors++; $display("FAIL ext_count: got %0d want %0d", q_count, m_cnt()); end
    tick(1'b0, 16'h0000, 1'b1);
    if (REL) begin
      checks++; if (q_data !== 16'hE02F) begin errors++; $display("FAIL ext_break: got %h want E02F", q_data); end
    end else begin
      checks++; if (q_count !== 5'd0) begin errors++; $display("FAIL ext_break_norel: got %0d want 0", q_count); end
    end
    drain();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) tick(1'b1, {8'h1C, 8'(8'h61 + i)}, 1'b0);
    checks++; if (q_count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d want 16", q_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (q_data !== 16'h8061) begin errors++; $display("FAIL ovf_head: got %h want 8061", q_data); end
    tick(1'b0, 16'h0000, 1'b1);
    tick(1'b1, 16'h1C72, 1'b0);
    checks++; if (q_count !== 5'd16) begin errors++; $display("FAIL ovf_refill: got %0d want 16", q_count); end
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        checks++; if (q_data !== 16'h9072) begin errors++; $display("FAIL ovf_tail: got %h want 9072", q_data); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b want 1", overflow); end
      end
      tick(1'b0, 16'h0000, 1'b1);
      checks++; if (q_data !== m_head() || overflow !== m_ovf) begin
        errors++; $display("FAIL ovf_drain%0d: got %h/%b want %h/%b", i, q_data, overflow, m_head(), m_ovf);
      end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) tick(1'b1, {8'h2A, 8'(8'h41 + i)}, 1'b0);
    tick(1'b1, 16'h2A7A, 1'b1);
    checks++; if (q_count !== 5'd16) begin errors++; $display("FAIL b2b_count: got %0d want 16", q_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b want 0", overflow); end
    checks++; if (q_data !== 16'h8042) begin errors++; $display("FAIL b2b_head: got %h want 8042", q_data); end
    for (int i = 0; i < 15; i++) tick(1'b0, 16'h0000, 1'b1);
    checks++; if (q_data !== 16'h807A) begin errors++; $display("FAIL b2b_tail: got %h want 807A", q_data); end
    drain();
  endtask

  task automatic test_random();
    logic [7:0] p, a;
    logic v, r;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       p = 8'hF0;
        1:       p = 8'hE0;
        default: p = 8'($urandom_range(0, 255));
      endcase
      a = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      v = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 35);
      tick(v, {p, a}, r);
      checks++; if (q_data !== m_head() || q_count !== m_cnt() || overflow !== m_ovf) begin
        errors++; $display("FAIL rand%0d: got %h/%0d/%b want %h/%0d/%b", i, q_data, q_count, overflow,
                           m_head(), m_cnt(), m_ovf);
      end
    end
    drain();
  endtask

  task automatic test_async_reset();
    drain();
    for (int i = 0; i < 17; i++) tick(1'b1, {8'h1C, 8'(8'h30 + i)}, 1'b0);
    for (int i = 0; i < 11; i++) tick(1'b0, 16'h0000, 1'b1);
    checks++; if (q_count !== 5'd5 || overflow !== 1'b1) begin
      errors++; $display("FAIL arst_setup: got %0d/%b want 5/1", q_count, overflow);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h1CE0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (q_data !== 16'h0000) begin errors++; $display("FAIL arst_qdata: got %h want 0000", q_data); end
    checks++; if (q_count !== 5'd0) begin errors++; $display("FAIL arst_count: got %0d want 0", q_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL arst_ovf: got %b want 0", overflow); end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick(1'b0, 16'h0000, 1'b1);
    checks++; if (q_count !== 5'd0 || q_data !== 16'h0000 || overflow !== 1'b0) begin
      errors++; $display("FAIL arst_empty_ren: got %h/%0d/%b want 0000/0/0", q_data, q_count, overflow);
    end
    // hist must be cleared by reset: a lone break is not extended.
    tick(1'b1, 16'hF041, 1'b0);
    checks++; if (q_data !== m_head() || q_count !== m_cnt()) begin
      errors++; $display("FAIL arst_hist: got %h/%0d want %h/%0d", q_data, q_count, m_head(), m_cnt());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_release();
    test_extended();
    test_overflow();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
